// File: rtl/cios_row_pe.sv
// One outer CIOS Montgomery row: t <- (t + a_i*B + m*N) / 2^WIDTH, streamed word by word.
// A single multiply-accumulate unit is time-shared across the LOAD, FOLD, MCALC, RED and FIN phases.
module cios_row_pe #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           n_prime,
  input  logic [WIDTH-1:0]           t_hi_in,
  input  logic                       t_top_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           b_j,
  input  logic [WIDTH-1:0]           n_j,
  input  logic [WIDTH-1:0]           t_j,
  output logic                       out_valid,
  output logic [$clog2(WORDS)-1:0]   out_idx,
  output logic [WIDTH-1:0]           out_word,
  output logic [WIDTH-1:0]           t_hi_out,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int SUM_W = 2 * WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FOLD, MCALC, RED, FIN} state_t;

  // Handshake: a word triple transfers on any rising edge where in_valid && in_ready;
  // out_valid is a one-cycle pulse with no backpressure.

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   np_q, np_d;
  logic [WIDTH-1:0]   thi_q, thi_d;
  logic [1:0]         ttop_q, ttop_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   sbuf_q [WORDS];
  logic [WIDTH-1:0]   sbuf_d [WORDS];
  logic [WIDTH-1:0]   nbuf_q [WORDS];
  logic [WIDTH-1:0]   nbuf_d [WORDS];
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [WIDTH-1:0]   out_word_q, out_word_d;
  logic [WIDTH-1:0]   t_hi_out_q, t_hi_out_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mac_x, mac_y, mac_z, mac_c;
  logic [SUM_W-1:0]   mac_sum;
  logic [WIDTH-1:0]   mac_lo, mac_hi;

  always_comb begin
    mac_x = '0;
    mac_y = '0;
    mac_z = '0;
    mac_c = '0;
    case (state_q)
      LOAD: begin
        mac_x = t_j;
        mac_y = a_q;
        mac_z = b_j;
        mac_c = c_q;
      end
      FOLD, FIN: begin
        mac_x = thi_q;
        mac_c = c_q;
      end
      MCALC: begin
        mac_y = sbuf_q[0];
        mac_z = np_q;
      end
      RED: begin
        mac_x = sbuf_q[idx_q];
        mac_y = m_q;
        mac_z = nbuf_q[idx_q];
        mac_c = c_q;
      end
      default: ;
    endcase
  end

  // Full-width product and sum; the carry split happens only after the whole sum exists.
  assign mac_sum = SUM_W'(mac_x) + SUM_W'(mac_y) * SUM_W'(mac_z) + SUM_W'(mac_c);
  assign mac_lo  = mac_sum[WIDTH-1:0];
  assign mac_hi  = mac_sum[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    c_d        = c_q;
    a_d        = a_q;
    np_d       = np_q;
    thi_d      = thi_q;
    ttop_d     = ttop_q;
    m_d        = m_q;
    sbuf_d     = sbuf_q;
    nbuf_d     = nbuf_q;
    out_valid_d = 1'b0;
    out_idx_d  = out_idx_q;
    out_word_d = out_word_q;
    t_hi_out_d = t_hi_out_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle; a start there belongs to the finished row.
        if (start && !done_q) begin
          a_d     = a_i;
          np_d    = n_prime;
          thi_d   = t_hi_in;
          ttop_d  = {1'b0, t_top_in};
          c_d     = '0;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          sbuf_d[idx_q] = mac_lo;
          nbuf_d[idx_q] = n_j;
          c_d           = mac_hi;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = FOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FOLD: begin
        thi_d   = mac_lo;
        ttop_d  = ttop_q + {1'b0, mac_hi[0]};
        c_d     = '0;
        state_d = MCALC;
      end
      MCALC: begin
        m_d     = mac_lo;
        c_d     = '0;
        idx_d   = '0;
        state_d = RED;
      end
      RED: begin
        c_d = mac_hi;
        if (idx_q != '0) begin
          out_valid_d = 1'b1;
          out_idx_d   = idx_q - 1'b1;
          out_word_d  = mac_lo;
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FIN: begin
        out_valid_d = 1'b1;
        out_idx_d   = LAST;
        out_word_d  = mac_lo;
        t_hi_out_d  = WIDTH'(ttop_q) + mac_hi;
        done_d      = 1'b1;
        c_d         = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      c_q         <= '0;
      a_q         <= '0;
      np_q        <= '0;
      thi_q       <= '0;
      ttop_q      <= '0;
      m_q         <= '0;
      sbuf_q      <= '{default: '0};
      nbuf_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_word_q  <= '0;
      t_hi_out_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      a_q         <= a_d;
      np_q        <= np_d;
      thi_q       <= thi_d;
      ttop_q      <= ttop_d;
      m_q         <= m_d;
      sbuf_q      <= sbuf_d;
      nbuf_q      <= nbuf_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_word_q  <= out_word_d;
      t_hi_out_q  <= t_hi_out_d;
      done_q      <= done_d;
    end
  end

  // m is chosen so the first reduction word cancels; the sum never reaches its top bit.
  always_ff @(posedge clk) begin
    if (state_q == RED && idx_q == '0) assert (mac_lo == '0);
    assert (!mac_sum[SUM_W-1]);
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_word  = out_word_q;
  assign t_hi_out  = t_hi_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cios_row_pe.sv
// Bench for cios_row_pe: an 8-bit/2-word instance for table vectors and corner cases,
// and a 32-bit/4-word instance chained into full Montgomery products.
module tb_cios_row_pe;

  localparam int WS = 8;
  localparam int NS = 2;
  localparam int WL = 32;
  localparam int NL = 4;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks;
  int   n_pass;

  logic          s_start, s_ttop, s_valid, s_ready, s_out_valid, s_busy, s_done;
  logic [WS-1:0] s_a, s_np, s_thi, s_b, s_n, s_t, s_out_word, s_thi_out;
  logic [0:0]    s_out_idx;

  logic          l_start, l_ttop, l_valid, l_ready, l_out_valid, l_busy, l_done;
  logic [WL-1:0] l_a, l_np, l_thi, l_b, l_n, l_t, l_out_word, l_thi_out;
  logic [1:0]    l_out_idx;

  logic [WS-1:0] exp8_q[$];
  logic [WL-1:0] exp32_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [15:0] b;
    logic [15:0] t;
    logic [7:0]  thi;
    logic        ttop;
    logic [15:0] n;
    logic [7:0]  np;
    int          stall;
    logic        hold;
    logic [7:0]  exp0;
    logic [7:0]  exp1;
    logic [7:0]  exphi;
  } vec8_t;

  vec8_t tbl[$];

  cios_row_pe #(.WIDTH(WS), .WORDS(NS)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .a_i(s_a), .n_prime(s_np),
    .t_hi_in(s_thi), .t_top_in(s_ttop), .in_valid(s_valid), .in_ready(s_ready),
    .b_j(s_b), .n_j(s_n), .t_j(s_t), .out_valid(s_out_valid), .out_idx(s_out_idx),
    .out_word(s_out_word), .t_hi_out(s_thi_out), .busy(s_busy), .done(s_done)
  );

  cios_row_pe #(.WIDTH(WL), .WORDS(NL)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .a_i(l_a), .n_prime(l_np),
    .t_hi_in(l_thi), .t_top_in(l_ttop), .in_valid(l_valid), .in_ready(l_ready),
    .b_j(l_b), .n_j(l_n), .t_j(l_t), .out_valid(l_out_valid), .out_idx(l_out_idx),
    .out_word(l_out_word), .t_hi_out(l_thi_out), .busy(l_busy), .done(l_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference row: whole-number CIOS step on the full accumulator value.
  function automatic logic [287:0] row_ref(input logic [287:0] t, input logic [287:0] a,
                                           input logic [287:0] b, input logic [287:0] n,
                                           input logic [287:0] np, input int w);
    logic [287:0] mask, m;
    mask = (288'(1) << w) - 288'(1);
    m    = (((t & mask) + a * (b & mask)) * np) & mask;
    return (t + a * b + m * n) >> w;
  endfunction

  function automatic logic [287:0] np_calc(input logic [287:0] n, input int w);
    logic [287:0] mask, inv, n0;
    mask = (288'(1) << w) - 288'(1);
    n0   = n & mask;
    inv  = n0;
    for (int k = 0; k < 6; k++) inv = (inv * (288'(2) - n0 * inv)) & mask;
    return (~inv + 288'(1)) & mask;
  endfunction

  function automatic vec8_t mk8(input logic [7:0] a, input logic [15:0] b, input logic [15:0] t,
                                input logic [7:0] thi, input logic ttop, input logic [15:0] n,
                                input logic [7:0] np, input int stall, input logic hold);
    vec8_t v;
    logic [287:0] tf, r;
    v.a = a; v.b = b; v.t = t; v.thi = thi; v.ttop = ttop;
    v.n = n; v.np = np; v.stall = stall; v.hold = hold;
    tf = 288'(t) | (288'(thi) << 16) | (288'(ttop) << 24);
    r  = row_ref(tf, 288'(a), 288'(b), 288'(n), 288'(np), WS);
    v.exp0 = r[7:0]; v.exp1 = r[15:8]; v.exphi = r[23:16];
    return v;
  endfunction

  // driver + scoreboard for the small instance; returns at the cycle after done
  task automatic run8(input int id, input vec8_t v);
    int st_cyc, done_cyc, exp_idx, n_words;
    logic [WS-1:0] exp_w;
    exp8_q.delete();
    exp8_q.push_back(v.exp0);
    exp8_q.push_back(v.exp1);
    exp_idx = 0; n_words = 0; done_cyc = -1;
    s_start = 1'b1; s_a = v.a; s_np = v.np; s_thi = v.thi; s_ttop = v.ttop;
    @(negedge clk);
    st_cyc  = cyc;
    s_start = 1'b0;
    for (int j = 0; j < NS; j++) begin
      if (j == 1) begin
        repeat (v.stall) begin
          s_valid = 1'b0; s_b = WS'($urandom); s_n = WS'($urandom); s_t = WS'($urandom);
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_b = v.b[j*WS +: WS]; s_n = v.n[j*WS +: WS]; s_t = v.t[j*WS +: WS];
      @(negedge clk);
    end
    check($sformatf("v%0d_in_ready_drop", id), s_ready, 0);
    s_valid = v.hold; s_start = v.hold;
    s_b = WS'($urandom); s_n = WS'($urandom); s_t = WS'($urandom);
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      if (s_out_valid) begin
        n_words++;
        if (exp8_q.size() > 0) begin
          exp_w = exp8_q.pop_front();
          check($sformatf("v%0d_word%0d", id, exp_idx), s_out_word, exp_w);
          check($sformatf("v%0d_idx%0d", id, exp_idx), s_out_idx, exp_idx);
          exp_idx++;
        end
      end
      if (s_done) begin
        done_cyc = cyc - st_cyc;
        check($sformatf("v%0d_t_hi_out", id), s_thi_out, v.exphi);
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("v%0d_latency", id), done_cyc, 7 + v.stall);
    check($sformatf("v%0d_word_count", id), n_words, NS);
    @(negedge clk);
    check($sformatf("v%0d_busy_after_done", id), s_busy, 0);
    check($sformatf("v%0d_done_pulse", id), s_done, 0);
    s_start = 1'b0; s_valid = 1'b0;
  endtask

  task automatic run32(input int id, input logic [WL-1:0] ai, input logic [127:0] b,
                       input logic [127:0] n, input logic [WL-1:0] np,
                       input logic [287:0] t_in, output logic [287:0] t_out);
    logic [287:0] r;
    int st_cyc, done_cyc, exp_idx, n_words;
    logic [WL-1:0] exp_w;
    r = row_ref(t_in, 288'(ai), 288'(b), 288'(n), 288'(np), WL);
    exp32_q.delete();
    for (int w = 0; w < NL; w++) exp32_q.push_back(r[w*WL +: WL]);
    exp_idx = 0; n_words = 0; done_cyc = -1;
    l_start = 1'b1; l_a = ai; l_np = np; l_thi = t_in[NL*WL +: WL]; l_ttop = t_in[(NL+1)*WL];
    @(negedge clk);
    st_cyc  = cyc;
    l_start = 1'b0;
    for (int j = 0; j < NL; j++) begin
      l_valid = 1'b1;
      l_b = b[j*WL +: WL]; l_n = n[j*WL +: WL]; l_t = t_in[j*WL +: WL];
      @(negedge clk);
    end
    l_valid = 1'b0;
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      if (l_out_valid) begin
        n_words++;
        if (exp32_q.size() > 0) begin
          exp_w = exp32_q.pop_front();
          check($sformatf("r%0d_word%0d", id, exp_idx), l_out_word, exp_w);
          check($sformatf("r%0d_idx%0d", id, exp_idx), l_out_idx, exp_idx);
          exp_idx++;
        end
      end
      if (l_done) begin
        done_cyc = cyc - st_cyc;
        check($sformatf("r%0d_t_hi_out", id), l_thi_out, r[NL*WL +: WL]);
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("r%0d_latency", id), done_cyc, 2 * NL + 3);
    check($sformatf("r%0d_word_count", id), n_words, NL);
    @(negedge clk);
    check($sformatf("r%0d_busy_after_done", id), l_busy, 0);
    t_out = r;
  endtask

  initial begin
    vec8_t v;
    int spurious;
    logic [287:0] nn, aa, bb, tt, tr, npl, npw;
    n_checks = 0; n_pass = 0;
    rst = 1'b0;
    s_start = 0; s_valid = 0; s_a = 0; s_np = 0; s_thi = 0; s_ttop = 0; s_b = 0; s_n = 0; s_t = 0;
    l_start = 0; l_valid = 0; l_a = 0; l_np = 0; l_thi = 0; l_ttop = 0; l_b = 0; l_n = 0; l_t = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", s_ready, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_l_busy", l_busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // table: hand-derived vectors first, then random ones scored by the model
    v = mk8(8'h01, 16'h0001, 16'h0000, 8'h00, 1'b0, 16'h00FB, 8'hCD, 0, 1'b0);
    v.exp0 = 8'hC9; v.exp1 = 8'h00; v.exphi = 8'h00; tbl.push_back(v);
    v = mk8(8'hFF, 16'hFFFF, 16'hFFFF, 8'h00, 1'b0, 16'h00FB, 8'hCD, 0, 1'b0);
    v.exp0 = 8'hFF; v.exp1 = 8'hFF; v.exphi = 8'h00; tbl.push_back(v);
    v = mk8(8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b0, 16'h00FB, 8'hCD, 0, 1'b0);
    v.exp0 = 8'hFF; v.exp1 = 8'hFE; v.exphi = 8'h01; tbl.push_back(v);
    v = mk8(8'h01, 16'h0001, 16'h0000, 8'h00, 1'b0, 16'h00FB, 8'hCD, 3, 1'b0);
    v.exp0 = 8'hC9; v.exp1 = 8'h00; v.exphi = 8'h00; tbl.push_back(v);
    v = mk8(8'h01, 16'h0001, 16'h0000, 8'h00, 1'b0, 16'h00FB, 8'hCD, 0, 1'b1);
    v.exp0 = 8'hC9; v.exp1 = 8'h00; v.exphi = 8'h00; tbl.push_back(v);
    for (int i = 0; i < 6; i++) begin
      nn  = 288'($urandom_range(1, 65535) | 1);
      npw = np_calc(nn, WS);
      tbl.push_back(mk8(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom),
                        1'($urandom_range(0, 1)), nn[15:0], npw[7:0],
                        $urandom_range(0, 2), 1'($urandom_range(0, 1))));
    end
    for (int i = 0; i < tbl.size(); i++) run8(i, tbl[i]);

    // reset mid-LOAD after one handshake, with non-zero registered outputs beforehand
    run8(90, tbl[2]);
    s_start = 1'b1; s_a = 8'h01; s_np = 8'hCD; s_thi = 8'h00; s_ttop = 1'b0;
    @(negedge clk);
    s_start = 1'b0; s_valid = 1'b1; s_b = 8'h01; s_n = 8'hFB; s_t = 8'h00;
    @(negedge clk);
    s_valid = 1'b0;
    check("midload_busy", s_busy, 1);
    rst = 1'b0;
    #1;
    check("abort_in_ready", s_ready, 0);
    check("abort_busy", s_busy, 0);
    check("abort_out_valid", s_out_valid, 0);
    check("abort_done", s_done, 0);
    check("abort_out_word", s_out_word, 0);
    check("abort_out_idx", s_out_idx, 0);
    check("abort_t_hi_out", s_thi_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_out_valid || s_done || s_busy) spurious++;
    end
    check("post_reset_quiet", spurious, 0);
    run8(91, tbl[0]);

    // chained 32-bit rows forming Montgomery products, start the cycle after each done
    for (int p = 0; p < 3; p++) begin
      nn = 288'({$urandom, $urandom, $urandom, $urandom});
      nn[127] = 1'b1; nn[0] = 1'b1;
      aa  = 288'({$urandom, $urandom, $urandom, $urandom}) % nn;
      bb  = 288'({$urandom, $urandom, $urandom, $urandom}) % nn;
      npl = np_calc(nn, WL);
      tt  = '0;
      for (int i = 0; i < NL; i++)
        run32(p * 10 + i, aa[i*WL +: WL], bb[127:0], nn[127:0], npl[WL-1:0], tt, tt);
      check($sformatf("p%0d_bound", p), tt < (nn << 1), 1);
      tr = tt;
      if (tr >= nn) tr = tr - nn;
      check($sformatf("p%0d_mont", p), (tr << 128) % nn, (aa * bb) % nn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cios_row_pe.md
Name: cios_row_pe

Overview:
- Multi-word successor to the single-word Montgomery PE.
- Executes one complete outer iteration of CIOS Montgomery multiplication on a WORDS-word operand: t <- (t + a_i*B + m*N) / 2^WIDTH, with m = (t0 + a_i*b0)*n_prime mod 2^WIDTH.
- Sits between the operand word buffers and the modexp sequencer. The sequencer issues WORDS rows per Montgomery product.
- Replaces the fixed three-multiply PE with a parametrised, streaming, handshaked row engine.

Parameters:
- WIDTH, 32, word width in bits.
- WORDS, 4, operand length in words (>=2).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin a row; sampled only in IDLE
- a_i  input  WIDTH  multiplier word for this row, captured on start
- n_prime  input  WIDTH  -N^-1 mod 2^WIDTH, captured on start
- t_hi_in  input  WIDTH  incoming t[WORDS], captured on start
- t_top_in  input  1  incoming t[WORDS+1], captured on start
- in_valid  input  1  word triple valid
- in_ready  output  1  PE accepts triple
- b_j  input  WIDTH  word j of B
- n_j  input  WIDTH  word j of N
- t_j  input  WIDTH  word j of current accumulator t
- out_valid  output  1  result word valid, one-cycle pulse, no backpressure
- out_idx  output  $clog2(WORDS)  index of out_word
- out_word  output  WIDTH  new t word
- t_hi_out  output  WIDTH  new t[WORDS], valid when done=1
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at row completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. in_ready, out_valid, done and busy are 0. out_word, out_idx and t_hi_out are 0. Internal buffers and carries are cleared. A reset asserted mid-row aborts the row with no further output.
- States: IDLE -> LOAD -> FOLD -> MCALC -> RED -> FIN -> IDLE.
- IDLE:
  - start=1 captures a_i, n_prime, t_hi_in and t_top_in, then goes to LOAD.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1. Each in_valid&&in_ready handshake at index j (0..WORDS-1) computes (C,S) = t_j + a_i*b_j + C, where C is WIDTH bits and starts at 0.
  - S is stored in sbuf[j] and n_j in nbuf[j].
  - in_valid is allowed to stall for any number of cycles. The state is held and nothing changes.
  - After handshake WORDS-1 the state moves to FOLD, and in_ready falls the next cycle.
  - in_valid outside LOAD is ignored.
- FOLD (1 cycle): (C,S) = t_hi + C, with t_hi <- S and t_top <- t_top + C (fits in 2 bits, keep 2).
- MCALC (1 cycle): m = (sbuf[0]*n_prime)[WIDTH-1:0].
- RED (WORDS cycles, r=0..WORDS-1):
  - Each cycle computes (C,S) = sbuf[r] + m*nbuf[r] + C, with C reset to 0 at r=0.
  - r=0: S is discarded. S must equal 0; this is a verification assertion.
  - r>=1: out_valid=1, out_idx=r-1, out_word=S, registered the cycle after the computation.
- FIN (1 cycle):
  - (C,S) = t_hi + C.
  - Emits out_valid=1, out_idx=WORDS-1, out_word=S.
  - t_hi_out <- t_top + C, truncated to WIDTH bits (guaranteed <2 for t<2N).
  - done=1, then returns to IDLE.
- All products are full 2*WIDTH bits and all sums are 2*WIDTH+1 bits. There is no truncation before the carry split.
- Latency: start-to-done = WORDS (LOAD, zero-stall) + 1 + 1 + WORDS + 1 cycles. WIDTH=8 with WORDS=2 gives 7.
- Output words appear in ascending index order, exactly once per row.
- start asserted in the same cycle as done is ignored. The sequencer re-asserts start in the following cycle, and busy=0 in that cycle.

Test Plan:
- Reset/idle: rst low mid-LOAD after 1 handshake -> all outputs 0 immediately. No out_valid or done until a new start.
- Basic row, WIDTH=8, WORDS=2, N=0x00FB, n_prime=0xCD, a_i=0x01, B={0x01,0x00}, t=0, t_hi_in=0, t_top_in=0 -> out words {0xC9,0x00}, t_hi_out=0x00, done exactly 7 cycles after start.
- Carry propagation, WIDTH=8, WORDS=2, a_i=0xFF, B={0xFF,0xFF}, t={0xFF,0xFF}, t_hi_in=0, N=0x00FB, n_prime=0xCD -> outputs match a software CIOS model; check FOLD carry into t_top and t_hi_out<=1.
- Stalled input: in_valid dropped for 3 cycles between j=0 and j=1 -> same results as the basic row, latency +3, no spurious handshake.
- Ignored controls: start pulsed during RED and in_valid held high during RED/FIN -> no state disturbance, single done.
- Back-to-back rows, WIDTH=32, WORDS=4: 4 chained rows forming a full Montgomery product, start issued the cycle after each done -> final t equals A*B*R^-1 mod N (random vectors vs reference model).
